rx_port_sched: RTL and testbench

RX_PORT_SCHED -- requirements
Module: rx_port_sched

---
 rtl/rx_port_sched.sv | 243 ++++++++++++++++++++++++
 tb/tb_rx_port_sched.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_port_sched.sv
// rx_port_sched: picks one of four RX ports to hand to the frame consumer.
// Arbitration is by class (starved > almost-full > half-full > frame-only),
// then round-robin from rr_ptr within the winning class.
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   port_en[3:0]          per-port enable; disabled ports are never granted
//   frame_exist[3:0]      per-port complete frame present
//   afull_async[3:0]      per-port almost-full, foreign clock domain
//   half_async[3:0]       per-port half-full, foreign clock domain
//   sink_ready            consumer can take a new frame
//   grant_valid           grant offered (GRANT state)
//   grant_id[1:0]         granted port
//   grant_class[1:0]      class the grant was won at
//   grant_ack             consumer accepts the grant
//   done                  consumer finished the granted frame
//   timeout               one-cycle pulse when the BUSY watchdog expires
//   busy                  high in GRANT and BUSY
module rx_port_sched #(
    parameter int STARVE_LIMIT = 8,
    parameter int TIMEOUT_CYC  = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] port_en,
    input  logic [3:0] frame_exist,
    input  logic [3:0] afull_async,
    input  logic [3:0] half_async,
    input  logic       sink_ready,
    output logic       grant_valid,
    output logic [1:0] grant_id,
    output logic [1:0] grant_class,
    input  logic       grant_ack,
    input  logic       done,
    output logic       timeout,
    output logic       busy
);

    localparam int SC_W = $clog2(STARVE_LIMIT + 1);
    localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [SC_W-1:0] SC_MAX  = SC_W'(STARVE_LIMIT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_BUSY  = 2'd2;

    logic [1:0]      state;
    logic [1:0]      state_nxt;

    logic [3:0]      afull_s1;
    logic [3:0]      afull_sync;
    logic [3:0]      half_s1;
    logic [3:0]      half_sync;

    logic [3:0]      elig;
    logic            any_elig;
    logic [1:0]      cls [4];
    logic [1:0]      top_cls;
    logic [1:0]      win_id;
    logic            win_found;

    logic [1:0]      rr_ptr;
    logic [SC_W-1:0] starve_cnt [4];
    logic [WD_W-1:0] wd;
    logic [1:0]      id_q;
    logic [1:0]      cls_q;

    logic            take_grant;
    logic            wd_expire;

    // Two-flop synchronizers for the write-clock-domain FIFO levels.
    always_ff @(posedge clk) begin
        if (rst) begin
            afull_s1   <= '0;
            afull_sync <= '0;
            half_s1    <= '0;
            half_sync  <= '0;
        end else begin
            afull_s1   <= afull_async;
            afull_sync <= afull_s1;
            half_s1    <= half_async;
            half_sync  <= half_s1;
        end
    end

    assign elig     = port_en & frame_exist;
    assign any_elig = |elig;

    // Per-port class, highest class present, then round-robin search
    // from rr_ptr restricted to eligible ports of that class.
    always_comb begin
        logic [1:0] cand;
        cand      = rr_ptr;
        top_cls   = 2'd0;
        win_found = 1'b0;
        win_id    = rr_ptr;
        for (int p = 0; p < 4; p++) begin
            if (starve_cnt[p] >= SC_MAX) begin
                cls[p] = 2'd3;
            end else if (afull_sync[p]) begin
                cls[p] = 2'd2;
            end else if (half_sync[p]) begin
                cls[p] = 2'd1;
            end else begin
                cls[p] = 2'd0;
            end
        end
        for (int p = 0; p < 4; p++) begin
            if (elig[p] && (cls[p] > top_cls)) begin
                top_cls = cls[p];
            end
        end
        for (int i = 0; i < 4; i++) begin
            cand = rr_ptr + 2'(i);
            if (!win_found && elig[cand] && (cls[cand] == top_cls)) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    assign take_grant = sink_ready && any_elig;
    assign wd_expire  = (wd == WD_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (take_grant) begin
                    state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                // Only the ack moves us on; the grant is never withdrawn.
                if (grant_ack) begin
                    state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (done || wd_expire) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Output logic; done on the last watchdog cycle suppresses timeout.
    always_comb begin
        grant_valid = 1'b0;
        busy        = 1'b0;
        timeout     = 1'b0;
        grant_id    = 2'd0;
        grant_class = 2'd0;
        case (state)
            S_IDLE: begin
                grant_id    = id_q;
                grant_class = cls_q;
            end
            S_GRANT: begin
                grant_valid = 1'b1;
                busy        = 1'b1;
                grant_id    = id_q;
                grant_class = cls_q;
            end
            S_BUSY: begin
                busy        = 1'b1;
                timeout     = wd_expire && !done;
                grant_id    = id_q;
                grant_class = cls_q;
            end
            default: begin
                grant_valid = 1'b0;
            end
        endcase
    end

    // Grant registers, round-robin pointer, starvation counters, watchdog.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_q   <= 2'd0;
            cls_q  <= 2'd0;
            rr_ptr <= 2'd0;
            wd     <= '0;
            for (int p = 0; p < 4; p++) begin
                starve_cnt[p] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    wd <= '0;
                    if (take_grant) begin
                        id_q  <= win_id;
                        cls_q <= top_cls;
                    end
                end
                S_GRANT: begin
                    wd <= '0;
                    if (grant_ack) begin
                        rr_ptr <= id_q + 2'd1;
                        for (int p = 0; p < 4; p++) begin
                            if (2'(p) == id_q) begin
                                starve_cnt[p] <= '0;
                            end else if (elig[p]) begin
                                // Saturate so a long-starved port stays top class.
                                if (starve_cnt[p] < SC_MAX) begin
                                    starve_cnt[p] <= starve_cnt[p] + SC_W'(1);
                                end
                            end else begin
                                starve_cnt[p] <= '0;
                            end
                        end
                    end
                end
                S_BUSY: begin
                    if (!wd_expire) begin
                        wd <= wd + WD_W'(1);
                    end
                end
                default: begin
                    id_q  <= 2'd0;
                    cls_q <= 2'd0;
                    wd    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_port_sched.sv
// Directed-vector bench for rx_port_sched with STARVE_LIMIT=8, TIMEOUT_CYC=16.
// Expected grant ids and classes below are worked out by hand from the rules.
module tb_rx_port_sched;

    logic       clk;
    logic       rst;
    logic [3:0] port_en;
    logic [3:0] frame_exist;
    logic [3:0] afull_async;
    logic [3:0] half_async;
    logic       sink_ready;
    logic       grant_valid;
    logic [1:0] grant_id;
    logic [1:0] grant_class;
    logic       grant_ack;
    logic       done;
    logic       timeout;
    logic       busy;

    int n_total;
    int n_bad;

    rx_port_sched #(
        .STARVE_LIMIT(8),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .port_en    (port_en),
        .frame_exist(frame_exist),
        .afull_async(afull_async),
        .half_async (half_async),
        .sink_ready (sink_ready),
        .grant_valid(grant_valid),
        .grant_id   (grant_id),
        .grant_class(grant_class),
        .grant_ack  (grant_ack),
        .done       (done),
        .timeout    (timeout),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input string tag);
        int n;
        n = 0;
        while (!grant_valid && n < 20) begin
            tick();
            n++;
        end
        chk(tag, int'(grant_valid), 1);
    endtask

    // One full grant / ack / done handshake with id and class checks.
    task automatic do_grant(input string tag, input int exp_id, input int exp_cls);
        wait_grant({tag, "_wait"});
        chk({tag, "_id"}, int'(grant_id), exp_id);
        chk({tag, "_cls"}, int'(grant_class), exp_cls);
        grant_ack = 1'b1;
        tick();
        grant_ack = 1'b0;
        chk({tag, "_busy"}, int'(busy), 1);
        chk({tag, "_gv0"}, int'(grant_valid), 0);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk({tag, "_idle"}, int'(busy), 0);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit got=1 exp=0");
        $fatal(1, "time limit");
    end

    initial begin
        n_total     = 0;
        n_bad       = 0;
        rst         = 1'b1;
        port_en     = 4'b0000;
        frame_exist = 4'b0000;
        afull_async = 4'b0000;
        half_async  = 4'b0000;
        sink_ready  = 1'b0;
        grant_ack   = 1'b0;
        done        = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_gv", int'(grant_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_id", int'(grant_id), 0);
        chk("rst_cls", int'(grant_class), 0);
        chk("rst_to", int'(timeout), 0);
        rst = 1'b0;

        // Plain round-robin: 0,1,2,3,0 at class 0
        port_en     = 4'b1111;
        frame_exist = 4'b1111;
        sink_ready  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            do_grant($sformatf("rr%0d", i), i % 4, 0);
        end

        // Almost-full port 1 beats port 0 once synchronized (rr_ptr=0)
        sink_ready = 1'b0;
        pulse_rst();
        frame_exist = 4'b0011;
        afull_async = 4'b0010;
        tick();
        tick();
        tick();
        sink_ready = 1'b1;
        do_grant("afull", 1, 2);

        // Ports 0-2 almost-full, port 3 frame-only: promoted on 9th grant
        sink_ready = 1'b0;
        pulse_rst();
        frame_exist = 4'b1111;
        afull_async = 4'b0111;
        tick();
        tick();
        tick();
        sink_ready = 1'b1;
        do_grant("st1", 0, 2);
        do_grant("st2", 1, 2);
        do_grant("st3", 2, 2);
        do_grant("st4", 0, 2);
        do_grant("st5", 1, 2);
        do_grant("st6", 2, 2);
        do_grant("st7", 0, 2);
        do_grant("st8", 1, 2);
        do_grant("st9", 3, 3);

        // Grant to port 2 held while its frame/enable/sink all drop
        sink_ready = 1'b0;
        afull_async = 4'b0000;
        pulse_rst();
        frame_exist = 4'b0100;
        sink_ready  = 1'b1;
        wait_grant("hold_wait");
        chk("hold_id0", int'(grant_id), 2);
        frame_exist = 4'b0000;
        port_en     = 4'b0000;
        sink_ready  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("hold_gv%0d", i), int'(grant_valid), 1);
            chk($sformatf("hold_id%0d", i + 1), int'(grant_id), 2);
        end

        // Watchdog: timeout 16 cycles after the ack cycle
        grant_ack = 1'b1;
        tick();
        grant_ack = 1'b0;
        chk("wd_busy", int'(busy), 1);
        for (int i = 0; i < 15; i++) begin
            chk($sformatf("wd_quiet%0d", i), int'(timeout), 0);
            tick();
        end
        chk("wd_pulse", int'(timeout), 1);
        chk("wd_pulse_busy", int'(busy), 1);
        tick();
        chk("wd_after_to", int'(timeout), 0);
        chk("wd_after_busy", int'(busy), 0);
        chk("wd_after_gv", int'(grant_valid), 0);

        // done on the final watchdog cycle wins over timeout
        port_en     = 4'b1111;
        frame_exist = 4'b0100;
        sink_ready  = 1'b1;
        wait_grant("dw_wait");
        frame_exist = 4'b0000;
        grant_ack   = 1'b1;
        tick();
        grant_ack = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
        end
        chk("dw_to_pre", int'(timeout), 1);
        done = 1'b1;
        #1;
        chk("dw_to_done", int'(timeout), 0);
        tick();
        done = 1'b0;
        chk("dw_idle", int'(busy), 0);
        chk("dw_to_after", int'(timeout), 0);

        // Reset during BUSY clears everything
        frame_exist = 4'b1000;
        wait_grant("rb_wait");
        chk("rb_id", int'(grant_id), 3);
        grant_ack = 1'b1;
        tick();
        grant_ack = 1'b0;
        chk("rb_busy", int'(busy), 1);
        rst     = 1'b1;
        port_en = 4'b0000;
        tick();
        chk("rb_gv", int'(grant_valid), 0);
        chk("rb_busy0", int'(busy), 0);
        chk("rb_id0", int'(grant_id), 0);
        chk("rb_cls0", int'(grant_class), 0);
        chk("rb_to0", int'(timeout), 0);
        rst = 1'b0;

        // port_en=0 blocks every grant; stray ack/done ignored
        frame_exist = 4'b1111;
        sink_ready  = 1'b1;
        grant_ack   = 1'b1;
        done        = 1'b1;
        tick();
        grant_ack = 1'b0;
        done      = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("blk_gv%0d", i), int'(grant_valid), 0);
        end
        chk("blk_busy", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
